// File: rtl/ysyx_220066_iter_mdu.sv
// ysyx_220066_iter_mdu: iterative RV64M multiply/divide unit, one shift-add or restoring-subtract step per cycle
module ysyx_220066_iter_mdu #(
  parameter int XLEN    = 64,
  parameter bit WORD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      mdu_ctr,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = XLEN'($signed(32'h8000_0000));
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic word_q, word_d, neg_q, neg_d;
  logic [XLEN-1:0] m_q, m_d, result_q, result_d;
  logic [2*XLEN-1:0] p_q, p_d, p_step;
  logic w, sgn_a, sgn_b, sa, sb, div0, ovf, accept;
  logic [XLEN-1:0] ea, eb, ma, mb, fast, hi_v, rem_v, quo_v, raw;
  logic [XLEN:0] add_v, sub_v;
  function automatic logic [XLEN-1:0] sx32(input logic [XLEN-1:0] v);
    return XLEN'($signed(v[31:0]));
  endfunction
  always_comb begin
    w      = WORD_EN & word & (mdu_ctr == 3'd0 | mdu_ctr[2]);
    sgn_a  = mdu_ctr inside {3'd1, 3'd2, 3'd4, 3'd6};
    sgn_b  = mdu_ctr inside {3'd1, 3'd4, 3'd6};
    ea     = w ? (sgn_a ? sx32(src1) : XLEN'(src1[31:0])) : src1;
    eb     = w ? (sgn_b ? sx32(src2) : XLEN'(src2[31:0])) : src2;
    sa     = sgn_a & ea[XLEN-1];
    sb     = sgn_b & eb[XLEN-1];
    ma     = sa ? -ea : ea;
    mb     = sb ? -eb : eb;
    div0   = mdu_ctr[2] & ~|eb;
    ovf    = mdu_ctr[2] & ~mdu_ctr[0] & (&eb) & (ea == (w ? MIN_W : MIN_X));
    fast   = div0 ? (mdu_ctr[1] ? ea : '1) : (mdu_ctr[1] ? '0 : ea);
    accept = in_valid & ~flush & (state_q == IDLE);
    // mul: add multiplicand into the high half then shift right; div: shift left, subtract if it fits
    add_v  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : '0);
    sub_v  = p_q[2*XLEN-1:XLEN-1] - {1'b0, m_q};
    p_step = op_q[2] ? (sub_v[XLEN] ? {p_q[2*XLEN-2:0], 1'b0}
                                    : {sub_v[XLEN-1:0], p_q[XLEN-2:0], 1'b1})
                     : {add_v, p_q[XLEN-1:1]};
    hi_v   = neg_q ? ~p_step[2*XLEN-1:XLEN] + XLEN'(p_step[XLEN-1:0] == '0) : p_step[2*XLEN-1:XLEN];
    rem_v  = neg_q ? -p_step[2*XLEN-1:XLEN] : p_step[2*XLEN-1:XLEN];
    quo_v  = neg_q ? -p_step[XLEN-1:0] : p_step[XLEN-1:0];
    raw    = op_q[2] ? (op_q[1] ? rem_v : quo_v)
                     : (op_q == 3'd0 ? (word_q ? p_step[XLEN-1:0] >> (XLEN-32) : p_step[XLEN-1:0]) : hi_v);
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    word_d   = word_q;
    neg_d    = neg_q;
    m_d      = m_q;
    p_d      = p_q;
    result_d = result_q;
    if (accept) begin
      op_d    = mdu_ctr;
      word_d  = w;
      neg_d   = (&mdu_ctr[2:1]) ? sa : sa ^ sb;
      m_d     = mdu_ctr[2] ? mb : ma;
      p_d     = {{XLEN{1'b0}}, mdu_ctr[2] ? (w ? ma << (XLEN-32) : ma) : mb};
      cnt_d   = w ? CW'(32) : CW'(XLEN);
      state_d = (div0 | ovf) ? DONE : CALC;
      if (div0 | ovf) result_d = w ? sx32(fast) : fast;
    end else if (state_q == CALC) begin
      p_d   = p_step;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d  = DONE;
        result_d = word_q ? sx32(raw) : raw;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
    if (flush) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      m_q      <= '0;
      p_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      m_q      <= m_d;
      p_q      <= p_d;
      result_q <= result_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign result    = result_q;
endmodule

// File: tb/tb_ysyx_220066_iter_mdu.sv
// tb_ysyx_220066_iter_mdu: directed vectors for the iterative MDU at XLEN=64
module tb_ysyx_220066_iter_mdu;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, word = 1'b0;
  logic [2:0] mdu_ctr = '0;
  logic [63:0] src1 = '0, src2 = '0, result;
  logic in_ready, out_valid, busy;
  int n_cmp = 0, n_err = 0;
  ysyx_220066_iter_mdu #(.XLEN(64), .WORD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mdu_ctr(mdu_ctr), .word(word), .src1(src1), .src2(src2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] c, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    mdu_ctr = c; word = w; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  task automatic retire();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask
  task automatic run(input string tag, input logic [2:0] c, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    issue(c, w, a, b);
    wait_done(lat);
    chk(tag, result, exp);
    if (exp_lat > 0) chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    retire();
  endtask
  initial begin
    int lat, seen;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", result, 64'd0);
    run("mul", 3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 65);
    run("mulh", 3'd1, 1'b0, '1, '1, 64'd0, 0);
    run("mulhu", 3'd3, 1'b0, '1, 64'd2, 64'd1, 0);
    run("mulhsu", 3'd2, 1'b0, '1, 64'd2, '1, 0);
    run("mulh_mix", 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("mulw", 3'd0, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run("div0", 3'd4, 1'b0, 64'd7, 64'd0, '1, 1);
    run("rem0", 3'd6, 1'b0, 64'd7, 64'd0, 64'd7, 1);
    run("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
    run("rem_neg", 3'd6, 1'b0, -64'sd7, 64'd2, '1, 0);
    run("div_neg", 3'd4, 1'b0, -64'sd7, 64'd2, -64'sd3, 0);
    run("divu", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    run("divw", 3'd4, 1'b1, 64'h1_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 33);
    run("remuw", 3'd7, 1'b1, 64'hFFFF_FFFF, 64'h10, 64'd15, 33);
    run("divuw0", 3'd5, 1'b1, 64'h5, 64'hFFFF_FFFF_0000_0000, '1, 1);
    issue(3'd0, 1'b0, 64'd3, 64'd5);
    wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_result", result, 64'd15);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    retire();
    chk("retired_idle", 64'(in_ready), 64'd1);
    issue(3'd5, 1'b0, 64'd1000, 64'd3);
    repeat (19) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1 seen += int'(out_valid);
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    run("after_flush", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    @(negedge clk);
    mdu_ctr = 3'd0; word = 1'b0; src1 = 64'd9; src2 = 64'd9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    chk("flush_same_busy", 64'(busy), 64'd0);
    issue(3'd0, 1'b0, 64'h1234, 64'h5678);
    repeat (10) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_result", result, 64'd0);
    run("after_rst", 3'd0, 1'b0, 64'h1234, 64'h5678, 64'h0626_0060, 65);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
